spi_readback_tx: RTL and testbench

SPI slave transmitter that returns status and readback bytes from the FPGA to the host MCU on MISO. It is the return path paired with the SPI command receiver. The block drains a first-word-fall-through response FIFO in the system clock domain and serialises each byte MSB-first. SPI pins are oversampled in the single system clock domain, so there is no spi_clk clock domain.

---
 rtl/mch3d_spi_pkg.sv | 21 ++
 rtl/spi_pin_sync.sv | 33 +++
 rtl/spi_readback_tx.sv | 129 ++++++++++++
 tb/tb_spi_readback_tx.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mch3d_spi_pkg.sv
// Shared definitions for the MCH3D SPI command receiver and readback transmitter.
package mch3d_spi_pkg;

  localparam int SPI_BYTE_W = 8;

  typedef logic [2:0] bit_cnt_t;

  localparam logic [SPI_BYTE_W-1:0] IDLE_BYTE_DEFAULT = 8'hFF;
  localparam bit_cnt_t              BIT_CNT_LAST      = 3'd7;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_tx_state_t;

  // One MSB-first shift step: the next bit moves into the MSB, LSB fills with 0.
  function automatic logic [SPI_BYTE_W-1:0] shift_msb_first(input logic [SPI_BYTE_W-1:0] d);
    return {d[SPI_BYTE_W-2:0], 1'b0};
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-stage synchroniser for a slow SPI pin sampled by the system clock.
// A history flop behind the last stage turns the synchronised level into
// single-cycle rise and fall pulses.
module spi_pin_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_r;
  logic              hist_r;

  // Synchroniser chain plus one history flop for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_r <= '0;
      hist_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[STAGES-2:0], pin};
      hist_r <= sync_r[STAGES-1];
    end
  end

  assign level = sync_r[STAGES-1];
  assign rise  = sync_r[STAGES-1] & ~hist_r;
  assign fall  = ~sync_r[STAGES-1] & hist_r;

endmodule

// File: rtl/spi_readback_tx.sv
// SPI mode-0 slave transmitter: drains a FWFT response FIFO and shifts each
// byte out on MISO, MSB first. The SPI pins are oversampled in the clk domain.
module spi_readback_tx
  import mch3d_spi_pkg::*;
#(
  parameter int                    SYNC_STAGES = 2,
  parameter logic [SPI_BYTE_W-1:0] IDLE_BYTE   = IDLE_BYTE_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  spi_clk,
  input  logic                  spi_cs,
  output logic                  spi_miso,
  output logic                  spi_miso_oe,
  input  logic [SPI_BYTE_W-1:0] resp_rddata,
  input  logic                  resp_empty,
  output logic                  resp_pop,
  output logic                  tx_underrun,
  output logic                  tx_byte_done
);

  // Synchronised pin views. Only the falling SCK edge and the CS edges drive
  // the FSM; rising SCK edges belong to the host, which samples MISO on them.
  logic sck_level_s;
  logic sck_rise_s;
  logic sck_fall_s;
  logic cs_level_s;
  logic cs_rise_s;
  logic cs_fall_s;
  logic unused_sync_s;

  spi_pin_sync #(.STAGES(SYNC_STAGES)) u_sck_sync (
    .clk   (clk),
    .rst   (rst),
    .pin   (spi_clk),
    .level (sck_level_s),
    .rise  (sck_rise_s),
    .fall  (sck_fall_s)
  );

  spi_pin_sync #(.STAGES(SYNC_STAGES)) u_cs_sync (
    .clk   (clk),
    .rst   (rst),
    .pin   (spi_cs),
    .level (cs_level_s),
    .rise  (cs_rise_s),
    .fall  (cs_fall_s)
  );

  assign unused_sync_s = ^{sck_level_s, sck_rise_s, cs_level_s};

  spi_tx_state_t         state_r;
  spi_tx_state_t         state_n_s;
  logic [SPI_BYTE_W-1:0] shift_r;
  logic [SPI_BYTE_W-1:0] shift_n_s;
  bit_cnt_t              bit_cnt_r;
  bit_cnt_t              bit_cnt_n_s;
  logic [SPI_BYTE_W-1:0] load_data_s;

  // Byte presented at every byte boundary: FIFO head, or the idle filler when empty.
  assign load_data_s = resp_empty ? IDLE_BYTE : resp_rddata;

  // State, shift register and bit counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      shift_r   <= IDLE_BYTE;
      bit_cnt_r <= 3'd0;
    end else begin
      state_r   <= state_n_s;
      shift_r   <= shift_n_s;
      bit_cnt_r <= bit_cnt_n_s;
    end
  end

  // Next-state logic and the single-cycle pulses. CS deassertion takes
  // priority over a coincident SCK fall so an aborted byte never pops.
  always_comb begin
    state_n_s    = state_r;
    shift_n_s    = shift_r;
    bit_cnt_n_s  = bit_cnt_r;
    resp_pop     = 1'b0;
    tx_underrun  = 1'b0;
    tx_byte_done = 1'b0;
    case (state_r)
      IDLE: begin
        if (cs_rise_s) begin
          shift_n_s   = load_data_s;
          resp_pop    = ~resp_empty;
          tx_underrun = resp_empty;
          bit_cnt_n_s = 3'd0;
          state_n_s   = ACTIVE;
        end else begin
          state_n_s = IDLE;
        end
      end
      ACTIVE: begin
        if (cs_fall_s) begin
          state_n_s   = IDLE;
          bit_cnt_n_s = 3'd0;
          shift_n_s   = IDLE_BYTE;
        end else if (sck_fall_s) begin
          if (bit_cnt_r == BIT_CNT_LAST) begin
            // Byte boundary: reload immediately so bytes run back-to-back.
            tx_byte_done = 1'b1;
            shift_n_s    = load_data_s;
            resp_pop     = ~resp_empty;
            tx_underrun  = resp_empty;
            bit_cnt_n_s  = 3'd0;
          end else begin
            shift_n_s   = shift_msb_first(shift_r);
            bit_cnt_n_s = bit_cnt_r + 3'd1;
          end
        end else begin
          state_n_s = ACTIVE;
        end
      end
      default: begin
        state_n_s   = IDLE;
        shift_n_s   = IDLE_BYTE;
        bit_cnt_n_s = 3'd0;
      end
    endcase
  end

  assign spi_miso    = shift_r[SPI_BYTE_W-1];
  assign spi_miso_oe = (state_r == ACTIVE);

endmodule

// File: tb/tb_spi_readback_tx.sv
// Directed bench for spi_readback_tx: a small FWFT FIFO model feeds the DUT,
// the host side drives mode-0 SPI at a 16x clk ratio and samples MISO on the
// rising spi_clk edge.
module tb_spi_readback_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       spi_clk;
  logic       spi_cs;
  logic       spi_miso;
  logic       spi_miso_oe;
  logic [7:0] resp_rddata;
  logic       resp_empty;
  logic       resp_pop;
  logic       tx_underrun;
  logic       tx_byte_done;

  int checks = 0;
  int fails  = 0;

  // FIFO model
  logic [7:0] mem [0:15];
  logic [3:0] wr_ptr = 4'd0;
  logic [3:0] rd_ptr = 4'd0;

  // pulse bookkeeping
  int  pop_cnt      = 0;
  int  done_cnt     = 0;
  int  under_cnt    = 0;
  int  pop_err      = 0;
  int  cyc          = 0;
  int  last_pop_cyc = -1;
  logic prev_pop    = 1'b0;

  assign resp_empty  = (rd_ptr == wr_ptr);
  assign resp_rddata = mem[rd_ptr];

  always #5 clk = ~clk;

  spi_readback_tx #(.SYNC_STAGES(2), .IDLE_BYTE(8'hFF)) dut (
    .clk          (clk),
    .rst          (rst),
    .spi_clk      (spi_clk),
    .spi_cs       (spi_cs),
    .spi_miso     (spi_miso),
    .spi_miso_oe  (spi_miso_oe),
    .resp_rddata  (resp_rddata),
    .resp_empty   (resp_empty),
    .resp_pop     (resp_pop),
    .tx_underrun  (tx_underrun),
    .tx_byte_done (tx_byte_done)
  );

  // FIFO consumption and pulse counting
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    prev_pop <= resp_pop;
    if (resp_pop) begin
      rd_ptr       <= rd_ptr + 4'd1;
      pop_cnt      <= pop_cnt + 1;
      last_pop_cyc <= cyc;
      if (resp_empty || prev_pop) pop_err <= pop_err + 1;
    end
    if (tx_byte_done) done_cnt  <= done_cnt + 1;
    if (tx_underrun)  under_cnt <= under_cnt + 1;
  end

  task automatic push(input logic [7:0] d);
    mem[wr_ptr] = d;
    wr_ptr      = wr_ptr + 4'd1;
  endtask

  task automatic cs_up();
    @(negedge clk);
    spi_cs = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic cs_down();
    @(negedge clk);
    spi_cs = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  // One SPI clock: host samples MISO as it raises spi_clk, then drops it.
  task automatic sck_cycle(output logic b, output int fall_cyc);
    b       = spi_miso;
    spi_clk = 1'b1;
    repeat (8) @(negedge clk);
    spi_clk  = 1'b0;
    fall_cyc = cyc;
    repeat (8) @(negedge clk);
  endtask

  task automatic read_byte(output logic [7:0] d, output int fall_cyc);
    logic b;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      sck_cycle(b, fall_cyc);
      d = {d[6:0], b};
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; spi_clk = 1'b0; spi_cs = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (spi_miso !== 1'b1) begin fails++; $display("FAIL reset_miso: got %b expected 1", spi_miso); end
    checks++;
    if ({spi_miso_oe, resp_pop, tx_underrun, tx_byte_done} !== 4'b0000) begin
      fails++; $display("FAIL reset_outputs: got %b expected 0000", {spi_miso_oe, resp_pop, tx_underrun, tx_byte_done});
    end
    rst = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_single_byte();
    logic [7:0] d; int fc; int p0, u0, d0;
    push(8'hA5);
    p0 = pop_cnt; u0 = under_cnt; d0 = done_cnt;
    cs_up();
    checks++;
    if (spi_miso_oe !== 1'b1) begin fails++; $display("FAIL single_oe: got %b expected 1", spi_miso_oe); end
    checks++;
    if (pop_cnt - p0 !== 1) begin fails++; $display("FAIL single_pop_at_cs: got %0d expected 1", pop_cnt - p0); end
    read_byte(d, fc);
    checks++;
    if (d !== 8'hA5) begin fails++; $display("FAIL single_data: got %h expected a5", d); end
    checks++;
    if (done_cnt - d0 !== 1) begin fails++; $display("FAIL single_done: got %0d expected 1", done_cnt - d0); end
    checks++;
    if (pop_cnt - p0 !== 1) begin fails++; $display("FAIL single_pop_total: got %0d expected 1", pop_cnt - p0); end
    // the byte-boundary reload finds the FIFO empty
    checks++;
    if (under_cnt - u0 !== 1) begin fails++; $display("FAIL single_underrun: got %0d expected 1", under_cnt - u0); end
    checks++;
    if (resp_empty !== 1'b1) begin fails++; $display("FAIL single_fifo_empty: got %b expected 1", resp_empty); end
    cs_down();
    checks++;
    if ({spi_miso_oe, spi_miso} !== 2'b01) begin fails++; $display("FAIL single_idle: oe/miso got %b expected 01", {spi_miso_oe, spi_miso}); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d; int fc; int p0, u0, d0;
    push(8'h3C); push(8'hC3);
    p0 = pop_cnt; u0 = under_cnt; d0 = done_cnt;
    cs_up();
    read_byte(d, fc);
    checks++;
    if (d !== 8'h3C) begin fails++; $display("FAIL b2b_first: got %h expected 3c", d); end
    // second pop lands in the sck_fall cycle, SYNC_STAGES+1 clk edges after the pin edge
    checks++;
    if (last_pop_cyc !== fc + 2) begin fails++; $display("FAIL b2b_pop_cycle: got %0d expected %0d", last_pop_cyc, fc + 2); end
    read_byte(d, fc);
    checks++;
    if (d !== 8'hC3) begin fails++; $display("FAIL b2b_second: got %h expected c3", d); end
    checks++;
    if (pop_cnt - p0 !== 2) begin fails++; $display("FAIL b2b_pops: got %0d expected 2", pop_cnt - p0); end
    checks++;
    if (done_cnt - d0 !== 2) begin fails++; $display("FAIL b2b_done: got %0d expected 2", done_cnt - d0); end
    checks++;
    if (under_cnt - u0 !== 1) begin fails++; $display("FAIL b2b_underrun: got %0d expected 1", under_cnt - u0); end
    checks++;
    if (spi_miso !== 1'b1) begin fails++; $display("FAIL b2b_idle_byte: got %b expected 1", spi_miso); end
    cs_down();
  endtask

  task automatic test_empty();
    logic [7:0] d; int fc; int p0, u0;
    p0 = pop_cnt; u0 = under_cnt;
    cs_up();
    checks++;
    if (under_cnt - u0 !== 1) begin fails++; $display("FAIL empty_underrun_cs: got %0d expected 1", under_cnt - u0); end
    read_byte(d, fc);
    checks++;
    if (d !== 8'hFF) begin fails++; $display("FAIL empty_data: got %h expected ff", d); end
    checks++;
    if (pop_cnt - p0 !== 0) begin fails++; $display("FAIL empty_pops: got %0d expected 0", pop_cnt - p0); end
    // the 8th fall reloads IDLE_BYTE again from an empty FIFO
    checks++;
    if (under_cnt - u0 !== 2) begin fails++; $display("FAIL empty_underrun_total: got %0d expected 2", under_cnt - u0); end
    cs_down();
  endtask

  task automatic test_abort();
    logic [7:0] d; logic b; int fc; int p0, d0;
    push(8'h81); push(8'h7E);
    p0 = pop_cnt; d0 = done_cnt;
    cs_up();
    d = 8'h00;
    for (int i = 0; i < 3; i++) begin
      sck_cycle(b, fc);
      d = {d[6:0], b};
    end
    checks++;
    if (d[2:0] !== 3'b100) begin fails++; $display("FAIL abort_partial_bits: got %b expected 100", d[2:0]); end
    cs_down();
    checks++;
    if (pop_cnt - p0 !== 1) begin fails++; $display("FAIL abort_pops: got %0d expected 1", pop_cnt - p0); end
    checks++;
    if (done_cnt - d0 !== 0) begin fails++; $display("FAIL abort_done: got %0d expected 0", done_cnt - d0); end
    checks++;
    if ({spi_miso_oe, spi_miso} !== 2'b01) begin fails++; $display("FAIL abort_idle: oe/miso got %b expected 01", {spi_miso_oe, spi_miso}); end
    cs_up();
    read_byte(d, fc);
    checks++;
    if (d !== 8'h7E) begin fails++; $display("FAIL abort_next_txn: got %h expected 7e", d); end
    cs_down();
  endtask

  task automatic test_cs_sck_collision();
    logic [7:0] d; logic b; int fc; int p0, d0;
    push(8'h55); push(8'h66);
    p0 = pop_cnt; d0 = done_cnt;
    cs_up();
    sck_cycle(b, fc);
    spi_clk = 1'b1;
    repeat (8) @(negedge clk);
    spi_clk = 1'b0;
    spi_cs  = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (pop_cnt - p0 !== 1) begin fails++; $display("FAIL collide_pops: got %0d expected 1", pop_cnt - p0); end
    checks++;
    if (done_cnt - d0 !== 0) begin fails++; $display("FAIL collide_done: got %0d expected 0", done_cnt - d0); end
    checks++;
    if ({spi_miso_oe, spi_miso} !== 2'b01) begin fails++; $display("FAIL collide_idle: oe/miso got %b expected 01", {spi_miso_oe, spi_miso}); end
    cs_up();
    read_byte(d, fc);
    checks++;
    if (d !== 8'h66) begin fails++; $display("FAIL collide_next_txn: got %h expected 66", d); end
    cs_down();
  endtask

  task automatic test_reset_mid_byte();
    logic [7:0] d; logic b; int fc; int p0, u0, d0;
    push(8'h5A); push(8'h9B);
    cs_up();
    for (int i = 0; i < 5; i++) sck_cycle(b, fc);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({spi_miso_oe, spi_miso} !== 2'b01) begin fails++; $display("FAIL rstmid_outputs: oe/miso got %b expected 01", {spi_miso_oe, spi_miso}); end
    checks++;
    if (dut.bit_cnt_r !== 3'd0) begin fails++; $display("FAIL rstmid_bit_cnt: got %0d expected 0", dut.bit_cnt_r); end
    spi_cs = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    p0 = pop_cnt; u0 = under_cnt; d0 = done_cnt;
    repeat (20) @(negedge clk);
    checks++;
    if ((pop_cnt - p0) + (under_cnt - u0) + (done_cnt - d0) !== 0) begin
      fails++; $display("FAIL rstmid_no_pulses: got %0d pulses expected 0", (pop_cnt - p0) + (under_cnt - u0) + (done_cnt - d0));
    end
    checks++;
    if (spi_miso_oe !== 1'b0) begin fails++; $display("FAIL rstmid_oe_hold: got %b expected 0", spi_miso_oe); end
    // 5A was popped before reset and is lost; the next transaction gets 9B
    cs_up();
    read_byte(d, fc);
    checks++;
    if (d !== 8'h9B) begin fails++; $display("FAIL rstmid_next_txn: got %h expected 9b", d); end
    cs_down();
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_empty();
    test_abort();
    test_cs_sck_collision();
    test_reset_mid_byte();
    checks++;
    if (pop_err !== 0) begin fails++; $display("FAIL pop_protocol: got %0d bad pops expected 0", pop_err); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end

endmodule
